// File: rtl/corner_tracker.sv
// ---------------------------------------------------------------------------
// corner_tracker
//
// Collects up to MAX_CORNERS corner coordinates per video frame from the
// Harris stage. It keeps running x/y sums and publishes the list, the count,
// an overflow flag and the centroid (mean) of the stored corners once per
// frame.
//
// On every frame_start the live collection (slots, count, sums, overflow)
// is snapshotted into a shadow set and cleared in the same edge, so
// collection of the new frame continues without a gap. A 14-iteration
// restoring divider then turns the shadow sums into the centroid. The
// published outputs, and the frame_done pulse, appear 15 clocks after the
// frame_start edge. An empty frame skips the divide and publishes 1 clock
// after frame_start.
//
// Optional feature (macro CORNER_DEDUP_EN): when defined, a corner that lies
// within +/-DIST pixels in both axes of an already stored corner of the
// current frame is dropped. A dropped corner is not stored, not summed and
// does not count toward overflow.
//
// Parameters:
//   MAX_CORNERS  number of corner slots per frame (1..8)
//   DIST         dedup window half-width in pixels (used with CORNER_DEDUP_EN)
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous, active-high reset
//   frame_start   one-cycle pulse at the start of a frame
//   corner_valid  qualifies corner_x / corner_y
//   corner_x/y    10-bit corner coordinates
//   rd_idx        read index into the published list
//   rd_x/rd_y     published corner at rd_idx (0 when rd_idx >= num_corners)
//   num_corners   published corner count
//   centroid_x/y  published mean of the stored corners
//   overflow      published flag: previous frame offered too many corners
//   frame_done    one-cycle pulse when the published outputs update
// ---------------------------------------------------------------------------
module corner_tracker #(
    parameter int MAX_CORNERS = 4,
    parameter int DIST        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       corner_valid,
    input  logic [9:0] corner_x,
    input  logic [9:0] corner_y,
    input  logic [2:0] rd_idx,
    output logic [9:0] rd_x,
    output logic [9:0] rd_y,
    output logic [3:0] num_corners,
    output logic [9:0] centroid_x,
    output logic [9:0] centroid_y,
    output logic       overflow,
    output logic       frame_done
);

    typedef enum logic [1:0] {IDLE, COLLECT, DIV} state_t;

    localparam logic [3:0] MAX_C     = 4'(MAX_CORNERS);
    localparam logic [3:0] DIV_ITERS = 4'd14;

    if (MAX_CORNERS < 1 || MAX_CORNERS > 8 || DIST < 0) begin : g_param_check
        $error("corner_tracker: MAX_CORNERS must be 1..8 and DIST non-negative");
    end

    // Saturate a quotient into pixel range. A mean of 10-bit values always
    // fits, so the saturation never triggers in practice.
    function automatic logic [9:0] to_pixel(input logic [13:0] q);
        return (|q[13:10]) ? 10'h3FF : q[9:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;

    // live collection for the current frame
    logic [3:0]  count_q, count_d;
    logic [13:0] sum_x_q, sum_x_d;
    logic [13:0] sum_y_q, sum_y_d;
    logic        ovf_pending_q, ovf_pending_d;
    logic [9:0]  slot_x_q [MAX_CORNERS];
    logic [9:0]  slot_x_d [MAX_CORNERS];
    logic [9:0]  slot_y_q [MAX_CORNERS];
    logic [9:0]  slot_y_d [MAX_CORNERS];

    // snapshot of the finished frame (sums live in the quotient registers)
    logic [3:0]  sh_count_q, sh_count_d;
    logic        sh_ovf_q, sh_ovf_d;
    logic [9:0]  sh_slot_x_q [MAX_CORNERS];
    logic [9:0]  sh_slot_x_d [MAX_CORNERS];
    logic [9:0]  sh_slot_y_q [MAX_CORNERS];
    logic [9:0]  sh_slot_y_d [MAX_CORNERS];

    // restoring divider, x and y in parallel; remainder < divisor <= 8
    logic [3:0]  iter_q, iter_d;
    logic [13:0] quo_x_q, quo_x_d;
    logic [13:0] quo_y_q, quo_y_d;
    logic [3:0]  rem_x_q, rem_x_d;
    logic [3:0]  rem_y_q, rem_y_d;

    // published bank
    logic [3:0]  pub_count_q, pub_count_d;
    logic [9:0]  pub_cx_q, pub_cx_d;
    logic [9:0]  pub_cy_q, pub_cy_d;
    logic        pub_ovf_q, pub_ovf_d;
    logic        frame_done_q, frame_done_d;
    logic [9:0]  pub_slot_x_q [MAX_CORNERS];
    logic [9:0]  pub_slot_x_d [MAX_CORNERS];
    logic [9:0]  pub_slot_y_q [MAX_CORNERS];
    logic [9:0]  pub_slot_y_d [MAX_CORNERS];

    // ------------------------------------------------------------------
    // Proximity check against the stored slots of the current frame.
    // On a frame_start edge the incoming corner belongs to a fresh frame
    // with no stored slots, so it can never be a duplicate.
    // ------------------------------------------------------------------
    logic is_dup;

`ifdef CORNER_DEDUP_EN
    localparam logic [9:0] DIST_V = 10'(DIST);

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        is_dup = 1'b0;
        for (int i = 0; i < MAX_CORNERS; i++) begin
            if (!frame_start && (4'(i) < count_q) &&
                (abs_diff(corner_x, slot_x_q[i]) <= DIST_V) &&
                (abs_diff(corner_y, slot_y_q[i]) <= DIST_V)) begin
                is_dup = 1'b1;
            end
        end
    end
`else
    always_comb begin
        is_dup = 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic: collection, snapshot, divider and publish
    // ------------------------------------------------------------------
    logic        collecting;
    logic        take;
    logic [3:0]  base_count;
    logic [13:0] base_sum_x;
    logic [13:0] base_sum_y;
    logic        base_ovf;
    logic [4:0]  divisor;
    logic [4:0]  shift_x;
    logic [4:0]  shift_y;
    logic        ge_x;
    logic        ge_y;

    always_comb begin
        state_d       = state_q;
        sh_count_d    = sh_count_q;
        sh_ovf_d      = sh_ovf_q;
        iter_d        = iter_q;
        quo_x_d       = quo_x_q;
        quo_y_d       = quo_y_q;
        rem_x_d       = rem_x_q;
        rem_y_d       = rem_y_q;
        pub_count_d   = pub_count_q;
        pub_cx_d      = pub_cx_q;
        pub_cy_d      = pub_cy_q;
        pub_ovf_d     = pub_ovf_q;
        frame_done_d  = 1'b0;
        for (int i = 0; i < MAX_CORNERS; i++) begin
            sh_slot_x_d[i]  = sh_slot_x_q[i];
            sh_slot_y_d[i]  = sh_slot_y_q[i];
            pub_slot_x_d[i] = pub_slot_x_q[i];
            pub_slot_y_d[i] = pub_slot_y_q[i];
        end

        // A frame_start clears the live set in the same edge it is
        // snapshotted, so the accumulation below starts from zero and a
        // coincident corner lands in slot 0 of the new frame.
        collecting = frame_start || (state_q != IDLE);
        base_count = frame_start ? 4'd0  : count_q;
        base_sum_x = frame_start ? 14'd0 : sum_x_q;
        base_sum_y = frame_start ? 14'd0 : sum_y_q;
        base_ovf   = frame_start ? 1'b0  : ovf_pending_q;

        count_d       = base_count;
        sum_x_d       = base_sum_x;
        sum_y_d       = base_sum_y;
        ovf_pending_d = base_ovf;
        for (int i = 0; i < MAX_CORNERS; i++) begin
            slot_x_d[i] = frame_start ? 10'd0 : slot_x_q[i];
            slot_y_d[i] = frame_start ? 10'd0 : slot_y_q[i];
        end

        take = corner_valid && collecting && !is_dup;
        if (take) begin
            if (base_count < MAX_C) begin
                count_d = base_count + 4'd1;
                sum_x_d = base_sum_x + {4'd0, corner_x};
                sum_y_d = base_sum_y + {4'd0, corner_y};
                for (int i = 0; i < MAX_CORNERS; i++) begin
                    if (base_count == 4'(i)) begin
                        slot_x_d[i] = corner_x;
                        slot_y_d[i] = corner_y;
                    end
                end
            end else begin
                ovf_pending_d = 1'b1;
            end
        end

        // One restoring step: shift the next dividend bit into the
        // remainder and subtract the divisor when it fits.
        divisor = {1'b0, sh_count_q};
        shift_x = {rem_x_q, quo_x_q[13]};
        shift_y = {rem_y_q, quo_y_q[13]};
        ge_x    = (shift_x >= divisor);
        ge_y    = (shift_y >= divisor);

        // A frame_start always wins: it restarts the divide on the new
        // snapshot and silently drops any result still in flight.
        if (frame_start) begin
            state_d    = DIV;
            sh_count_d = count_q;
            sh_ovf_d   = ovf_pending_q;
            quo_x_d    = sum_x_q;
            quo_y_d    = sum_y_q;
            rem_x_d    = 4'd0;
            rem_y_d    = 4'd0;
            iter_d     = 4'd0;
            for (int i = 0; i < MAX_CORNERS; i++) begin
                sh_slot_x_d[i] = slot_x_q[i];
                sh_slot_y_d[i] = slot_y_q[i];
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                COLLECT: begin
                    state_d = COLLECT;
                end
                DIV: begin
                    if ((sh_count_q == 4'd0) || (iter_q == DIV_ITERS)) begin
                        state_d      = COLLECT;
                        frame_done_d = 1'b1;
                        pub_count_d  = sh_count_q;
                        pub_ovf_d    = sh_ovf_q;
                        pub_cx_d     = (sh_count_q == 4'd0) ? 10'd0 : to_pixel(quo_x_q);
                        pub_cy_d     = (sh_count_q == 4'd0) ? 10'd0 : to_pixel(quo_y_q);
                        for (int i = 0; i < MAX_CORNERS; i++) begin
                            pub_slot_x_d[i] = sh_slot_x_q[i];
                            pub_slot_y_d[i] = sh_slot_y_q[i];
                        end
                    end else begin
                        iter_d  = iter_q + 4'd1;
                        quo_x_d = {quo_x_q[12:0], ge_x};
                        quo_y_d = {quo_y_q[12:0], ge_y};
                        rem_x_d = ge_x ? 4'(shift_x - divisor) : shift_x[3:0];
                        rem_y_d = ge_y ? 4'(shift_y - divisor) : shift_y[3:0];
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers: one synchronous-reset block for the whole datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            sum_x_q       <= '0;
            sum_y_q       <= '0;
            ovf_pending_q <= 1'b0;
            sh_count_q    <= '0;
            sh_ovf_q      <= 1'b0;
            iter_q        <= '0;
            quo_x_q       <= '0;
            quo_y_q       <= '0;
            rem_x_q       <= '0;
            rem_y_q       <= '0;
            pub_count_q   <= '0;
            pub_cx_q      <= '0;
            pub_cy_q      <= '0;
            pub_ovf_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            for (int i = 0; i < MAX_CORNERS; i++) begin
                slot_x_q[i]     <= '0;
                slot_y_q[i]     <= '0;
                sh_slot_x_q[i]  <= '0;
                sh_slot_y_q[i]  <= '0;
                pub_slot_x_q[i] <= '0;
                pub_slot_y_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            sum_x_q       <= sum_x_d;
            sum_y_q       <= sum_y_d;
            ovf_pending_q <= ovf_pending_d;
            sh_count_q    <= sh_count_d;
            sh_ovf_q      <= sh_ovf_d;
            iter_q        <= iter_d;
            quo_x_q       <= quo_x_d;
            quo_y_q       <= quo_y_d;
            rem_x_q       <= rem_x_d;
            rem_y_q       <= rem_y_d;
            pub_count_q   <= pub_count_d;
            pub_cx_q      <= pub_cx_d;
            pub_cy_q      <= pub_cy_d;
            pub_ovf_q     <= pub_ovf_d;
            frame_done_q  <= frame_done_d;
            for (int i = 0; i < MAX_CORNERS; i++) begin
                slot_x_q[i]     <= slot_x_d[i];
                slot_y_q[i]     <= slot_y_d[i];
                sh_slot_x_q[i]  <= sh_slot_x_d[i];
                sh_slot_y_q[i]  <= sh_slot_y_d[i];
                pub_slot_x_q[i] <= pub_slot_x_d[i];
                pub_slot_y_q[i] <= pub_slot_y_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port: combinational lookup in the published bank
    // ------------------------------------------------------------------
    always_comb begin
        rd_x = 10'd0;
        rd_y = 10'd0;
        for (int i = 0; i < MAX_CORNERS; i++) begin
            if ((rd_idx == 3'(i)) && ({1'b0, rd_idx} < pub_count_q)) begin
                rd_x = pub_slot_x_q[i];
                rd_y = pub_slot_y_q[i];
            end
        end
    end

    assign num_corners = pub_count_q;
    assign centroid_x  = pub_cx_q;
    assign centroid_y  = pub_cy_q;
    assign overflow    = pub_ovf_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_corner_tracker.sv
// ---------------------------------------------------------------------------
// tb_corner_tracker
//
// Directed bench for corner_tracker (MAX_CORNERS=4, DIST=8). The stimulus
// process pushes the hand-computed publication expected for each frame_start
// into a queue, together with the cycle where frame_done must appear. An
// independent monitor pops an entry on every frame_done and compares the
// scalar outputs and the whole published list through rd_idx.
// ---------------------------------------------------------------------------
module tb_corner_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       corner_valid;
    logic [9:0] corner_x;
    logic [9:0] corner_y;
    logic [2:0] rd_idx;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic [3:0] num_corners;
    logic [9:0] centroid_x;
    logic [9:0] centroid_y;
    logic       overflow;
    logic       frame_done;

    corner_tracker #(
        .MAX_CORNERS(4),
        .DIST       (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .corner_valid(corner_valid),
        .corner_x    (corner_x),
        .corner_y    (corner_y),
        .rd_idx      (rd_idx),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .num_corners (num_corners),
        .centroid_x  (centroid_x),
        .centroid_y  (centroid_y),
        .overflow    (overflow),
        .frame_done  (frame_done)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]      done_cyc;
        logic [3:0]       count;
        logic [9:0]       cx;
        logic [9:0]       cy;
        logic             ovf;
        logic [7:0][9:0]  xs;
        logic [7:0][9:0]  ys;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // drives one cycle of inputs at the falling edge
    task automatic applyStimulus(input logic fs, input logic cv, input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        frame_start  = fs;
        corner_valid = cv;
        corner_x     = x;
        corner_y     = y;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);
    endtask

    task automatic corner(input int x, input int y);
        applyStimulus(1'b0, 1'b1, 10'(x), 10'(y));
    endtask

    // issues frame_start and, if requested, queues the publication it causes
    task automatic startFrame(input bit do_push, input int lat, input int cnt,
                              input int cx, input int cy, input int ovf,
                              input logic [7:0][9:0] xs, input logic [7:0][9:0] ys);
        exp_t e;
        applyStimulus(1'b1, 1'b0, 10'd0, 10'd0);
        if (do_push) begin
            e.done_cyc = 32'(cyc + 1 + lat);
            e.count    = 4'(cnt);
            e.cx       = 10'(cx);
            e.cy       = 10'(cy);
            e.ovf      = 1'(ovf);
            e.xs       = xs;
            e.ys       = ys;
            exp_q.push_back(e);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_num_corners", int'(num_corners), 0);
        checkOutput("rst_centroid_x",  int'(centroid_x), 0);
        checkOutput("rst_centroid_y",  int'(centroid_y), 0);
        checkOutput("rst_overflow",    int'(overflow), 0);
        checkOutput("rst_rd_x",        int'(rd_x), 0);
        checkOutput("rst_rd_y",        int'(rd_y), 0);
        checkOutput("rst_frame_done",  int'(frame_done), 0);
    endtask

    // monitor: every frame_done consumes one expected publication
    initial begin
        exp_t e;
        rd_idx = 3'd0;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_frame_done: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("done_cycle",  cyc, int'(e.done_cyc));
                    checkOutput("num_corners", int'(num_corners), int'(e.count));
                    checkOutput("centroid_x",  int'(centroid_x), int'(e.cx));
                    checkOutput("centroid_y",  int'(centroid_y), int'(e.cy));
                    checkOutput("overflow",    int'(overflow), int'(e.ovf));
                    for (int i = 0; i < 8; i++) begin
                        rd_idx = 3'(i);
                        #1;
                        checkOutput($sformatf("rd_x[%0d]", i), int'(rd_x), int'(e.xs[i]));
                        checkOutput($sformatf("rd_y[%0d]", i), int'(rd_y), int'(e.ys[i]));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0][9:0] ex;
        logic [7:0][9:0] ey;

        reset        = 1'b1;
        frame_start  = 1'b0;
        corner_valid = 1'b0;
        corner_x     = 10'd0;
        corner_y     = 10'd0;
        repeat (3) @(negedge clk);
        checkResetOutputs();
        reset = 1'b0;

        // first frame_start from IDLE: nothing collected yet, publishes zeros 1 clock later
        ex = '0; ey = '0;
        startFrame(1'b1, 1, 0, 0, 0, 0, ex, ey);
        corner(100, 50);
        corner(200, 150);
        idle(20);

        // two corners -> centroid (150,100)
        ex = '0; ey = '0;
        ex[0] = 10'd100; ey[0] = 10'd50;
        ex[1] = 10'd200; ey[1] = 10'd150;
        startFrame(1'b1, 15, 2, 150, 100, 0, ex, ey);

        // six corners while the divide runs: only the first four count
        corner(10, 20);
        corner(30, 40);
        corner(50, 60);
        corner(70, 80);
        corner(90, 100);
        corner(110, 120);
        idle(20);
        ex = '0; ey = '0;
        ex[0] = 10'd10; ey[0] = 10'd20;
        ex[1] = 10'd30; ey[1] = 10'd40;
        ex[2] = 10'd50; ey[2] = 10'd60;
        ex[3] = 10'd70; ey[3] = 10'd80;
        startFrame(1'b1, 15, 4, 40, 50, 1, ex, ey);
        idle(20);

        // empty frame: skipped divide, 1-clock publish
        ex = '0; ey = '0;
        startFrame(1'b1, 1, 0, 0, 0, 0, ex, ey);

        // close-together corners
        corner(100, 100);
        corner(105, 96);
        corner(120, 100);
        idle(20);
        ex = '0; ey = '0;
`ifdef CORNER_DEDUP_EN
        ex[0] = 10'd100; ey[0] = 10'd100;
        ex[1] = 10'd120; ey[1] = 10'd100;
        startFrame(1'b1, 15, 2, 110, 100, 0, ex, ey);
`else
        ex[0] = 10'd100; ey[0] = 10'd100;
        ex[1] = 10'd105; ey[1] = 10'd96;
        ex[2] = 10'd120; ey[2] = 10'd100;
        startFrame(1'b1, 15, 3, 108, 98, 0, ex, ey);
`endif

        // restart: second frame_start 5 clocks after the first
        corner(300, 200);
        idle(20);
        ex = '0; ey = '0;
        startFrame(1'b0, 0, 0, 0, 0, 0, ex, ey);
        corner(400, 300);
        corner(500, 100);
        idle(2);
        ex[0] = 10'd400; ey[0] = 10'd300;
        ex[1] = 10'd500; ey[1] = 10'd100;
        startFrame(1'b1, 15, 2, 450, 200, 0, ex, ey);
        idle(20);

        // reset in the middle of a divide aborts it
        corner(8, 8);
        corner(16, 24);
        idle(3);
        ex = '0; ey = '0;
        startFrame(1'b0, 0, 0, 0, 0, 0, ex, ey);
        idle(7);
        @(negedge clk);
        reset        = 1'b1;
        frame_start  = 1'b0;
        corner_valid = 1'b0;
        @(negedge clk);
        checkResetOutputs();
        @(negedge clk);
        reset = 1'b0;
        idle(20);

        // recovery: full frame after the reset
        ex = '0; ey = '0;
        startFrame(1'b1, 1, 0, 0, 0, 0, ex, ey);
        corner(100, 50);
        corner(200, 150);
        idle(3);
        ex[0] = 10'd100; ey[0] = 10'd50;
        ex[1] = 10'd200; ey[1] = 10'd150;
        startFrame(1'b1, 15, 2, 150, 100, 0, ex, ey);
        idle(1);

        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
